// File: rtl/rev_counter_pkg.sv
// rev_counter_pkg: shared definitions for the reversible counter.
//   DIR_UP / DIR_DOWN : encodings of the direction input `s`.
//   eff_mod()         : effective modulus, MOD==0 meaning 2^WIDTH (33 bits wide).
//   mod_legal()       : WIDTH in 2..32 and MOD <= 2^WIDTH.
//   div_legal()       : DIV in 1..65535.
package rev_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [32:0] eff_mod(input int unsigned width, input int unsigned mod);
        if (mod == 0) begin
            return 33'd1 << width;
        end
        return {1'b0, mod};
    endfunction

    function automatic bit mod_legal(input int unsigned width, input int unsigned mod);
        return (width >= 2) && (width <= 32) && ({1'b0, mod} <= (33'd1 << width));
    endfunction

    function automatic bit div_legal(input int unsigned div);
        return (div >= 1) && (div <= 65535);
    endfunction

endpackage

// File: rtl/rev_cnt_prescaler.sv
// rev_cnt_prescaler: divide-by-DIV clock-enable generator.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the prescaler
//   en   : count enable; the prescaler holds when low
//   clr  : synchronous clear (used on load)
//   tick : combinational, high on an enabled cycle with prescaler == DIV-1
module rev_cnt_prescaler
    import rev_counter_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] pre_q, pre_d;

    // With DIV=1 LAST is 0 and pre_q never leaves 0, so every enabled cycle ticks.
    assign tick = en && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/rev_counter_n.sv
// rev_counter_n: parametrised up/down counter with programmable modulus, synchronous
// load with clamp, clock-enable prescaler and terminal-count outputs.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   en   : count enable (count and prescaler hold when low)
//   s    : direction, 1 = up, 0 = down
//   ld   : synchronous load strobe (ignores en, clears the prescaler)
//   din  : load value, clamped to MOD-1
//   cnt  : registered count, always within 0..MOD-1
//   Rc   : combinational terminal count (cnt==MOD-1 going up, cnt==0 going down)
//   wrap : registered one-cycle pulse the cycle after a wrap
// Build option: define REV_COUNTER_SAT_EN to saturate at the limits instead of wrapping;
// wrap then pulses once per arrival at a limit.
module rev_counter_n
    import rev_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MOD   = 0,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             Rc,
    output logic             wrap
);

    if (!mod_legal(WIDTH, MOD)) begin : g_bad_mod
        $error("rev_counter_n: illegal WIDTH/MOD combination");
    end
    if (!div_legal(DIV)) begin : g_bad_div
        $error("rev_counter_n: DIV out of range 1..65535");
    end

    // One extra bit so that MOD == 2^WIDTH is representable.
    localparam logic [32:0]      MOD_FULL = eff_mod(WIDTH, MOD);
    localparam logic [WIDTH:0]   MOD_EFF  = MOD_FULL[WIDTH:0];
    localparam logic [WIDTH:0]   MOD_MAX  = MOD_EFF - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = MOD_MAX[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             at_limit;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] wrapped;
`ifdef REV_COUNTER_SAT_EN
    // Set once a saturating tick has pulsed wrap; cleared when cnt leaves the limit.
    logic             sat_q, sat_d;
`endif

    rev_cnt_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (ld),
        .tick (tick)
    );

    always_comb begin
        at_limit = (s == DIR_UP) ? ({1'b0, cnt_q} == MOD_MAX) : (cnt_q == '0);
        stepped  = (s == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        wrapped  = (s == DIR_UP) ? '0 : CNT_MAX;
        ld_val   = ({1'b0, din} >= MOD_EFF) ? CNT_MAX : din;
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
`ifdef REV_COUNTER_SAT_EN
        sat_d  = sat_q;
`endif
        if (ld) begin
            cnt_d = ld_val;
`ifdef REV_COUNTER_SAT_EN
            sat_d = 1'b0;
`endif
        end else if (tick) begin
            if (at_limit) begin
`ifdef REV_COUNTER_SAT_EN
                wrap_d = !sat_q;
                sat_d  = 1'b1;
`else
                cnt_d  = wrapped;
                wrap_d = 1'b1;
`endif
            end else begin
                cnt_d = stepped;
`ifdef REV_COUNTER_SAT_EN
                sat_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
`ifdef REV_COUNTER_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
`ifdef REV_COUNTER_SAT_EN
            sat_q  <= sat_d;
`endif
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign Rc   = at_limit;

endmodule

// File: doc/rev_counter_n.md
# rev_counter_n

Parametrised reversible (up/down) counter with programmable modulus, synchronous load, clock-enable prescaler and terminal-count outputs. It is the general-purpose successor to the fixed 16-bit reversible counter and serves as the counting core for timers, frequency dividers and display sequencers in the lab designs. Direction is selected per cycle by `s`. `Rc` flags the terminal value for cascading.

## Interface
- `WIDTH`, 16: counter width in bits (2..32).
- `MOD`, 0: modulus. The count range is 0..MOD-1. A value of 0 means 2^WIDTH. It is legal only when MOD ≤ 2^WIDTH.
- `DIV`, 1: prescaler ratio. The counter steps once every DIV enabled cycles (1..65535).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable. When low, the count and the prescaler both hold.
- `s` in 1: direction. 1 = up, 0 = down.
- `ld` in 1: synchronous load strobe.
- `din` in WIDTH: load value.
- `cnt` out WIDTH: current count (registered).
- `Rc` out 1: terminal count, combinational from `cnt` and `s`. It is 1 when counting up with `cnt`==MOD-1, or counting down with `cnt`==0.
- `wrap` out 1: registered one-cycle pulse, asserted the cycle after the counter wraps (or saturates, see Configuration).

## Operation
- Priority per rising edge: `rst` > `ld` > count step.
- Reset: `cnt`=0, `wrap`=0, prescaler=0. `Rc` then follows from `cnt`=0: it is 1 if `s`=0, else 0.
- Load: `cnt` takes `din`. If `din` ≥ MOD (effective modulus), `cnt` takes MOD-1. The prescaler is cleared, and `wrap` is 0 on the next cycle. Load ignores `en`.
- Tick: the prescaler counts enabled cycles from 0 to DIV-1. A tick occurs on an enabled cycle where prescaler==DIV-1, and the prescaler returns to 0 on that cycle. With DIV=1, every enabled cycle is a tick.
- On a tick, counting up: `cnt`==MOD-1 gives `cnt`=0 and `wrap`=1 next cycle; otherwise `cnt`+1.
- On a tick, counting down: `cnt`==0 gives `cnt`=MOD-1 and `wrap`=1 next cycle; otherwise `cnt`-1.
- On a non-tick cycle, `wrap`=0.
- Direction change mid-prescale: the `s` value sampled on the tick cycle decides the step. The prescaler is not cleared.
- Arithmetic is internally WIDTH+1 bits so that MOD=2^WIDTH compares correctly. `cnt` never leaves 0..MOD-1.

## Timing
- Step latency: `cnt` updates 1 cycle after a tick-qualified edge.
- Load latency: 1 cycle.
- `Rc` is combinational, with zero latency relative to `cnt` and `s`. It is intended to feed the `en` input of a cascaded stage so that both stages wrap on the same edge.
- `wrap` is coincident with the first cycle of the wrapped `cnt` value, and lasts exactly 1 cycle.
- Reset asserted mid-prescale: the prescaler and count clear on that edge. The first tick after reset release occurs DIV enabled cycles later.
- Simultaneous `ld` and tick: load wins, and the prescaler clears.

## Configuration
- `REV_COUNTER_SAT_EN`.
- Defined: the counter saturates instead of wrapping. Up at MOD-1 holds at MOD-1; down at 0 holds at 0. `wrap` pulses once, on the first tick that hits the limit. It pulses again only after `cnt` has left the limit (via a step in the other direction or a load). `Rc` is unchanged.
- Undefined: modular wrap as described in Operation.

## Structure
- Shared package `rev_counter_pkg` holds:
  - the direction constants `DIR_UP`=1 and `DIR_DOWN`=0;
  - the helper function computing the effective modulus (MOD==0 → 2^WIDTH);
  - the parameter legality checks (elaboration-time assertions on MOD and DIV).
- One sub-module, `rev_cnt_prescaler`: parameter DIV; ports clk, rst, en, clr, tick. It owns the divide-by-DIV counter. The top level holds the count register, the load/clamp logic, the `wrap` register and the `Rc` decode.

## Test plan
- Reset/up, WIDTH=4, MOD=10, DIV=1, `s`=1, `en`=1 for 12 cycles after `rst`: `cnt` runs 0..9,0,1. `Rc`=1 while `cnt`=9. `wrap`=1 for exactly the cycle `cnt` is first 0 after 9.
- Down wrap, same configuration, `s`=0 from reset: `cnt` runs 0,9,8,… `Rc`=1 at `cnt`=0. `wrap` pulses when `cnt` becomes 9.
- Load clamp: `ld`=1 with `din`=13 (MOD=10) gives `cnt`=9 next cycle. `ld`=1 and `en` tick on the same edge with `din`=4 gives `cnt`=4, not 5.
- Prescaler, DIV=5, WIDTH=16, MOD=0, `s`=1: `cnt` increments every 5th cycle. Dropping `en` for 3 cycles delays the next step by exactly 3. `rst` at prescaler=3 restarts the 5-cycle count.
- Direction toggle: `s` toggles every 5 cycles with `clk` period 100 ns (500 ns high, 500 ns low) from `cnt`=0. `cnt` runs 0,65535,65534,65533,65532 while down, then climbs back. The 16-bit full-range wrap is checked.
- With `REV_COUNTER_SAT_EN` (MOD=10, up): `cnt` holds at 9 and `wrap` pulses once. `s`=0 for one tick then `s`=1 gives 8,9 and `wrap` pulses again.
